// File: rtl/axi_read_arbiter_pkg.sv
// Shared types and constants for the two-master AXI read arbiter.
// Imported by the arbiter and by anything that drives or observes it.
package axi_read_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } arb_state_e;

    localparam logic [2:0] AXI_SIZE_2B     = 3'd1;
    localparam logic [2:0] AXI_SIZE_4B     = 3'd2;
    localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
    localparam logic [1:0] AXI_BURST_INCR  = 2'd1;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    // rr_ptr = 0 prefers M0, 1 prefers M1; fixed priority always favours M1.
    function automatic logic [1:0] pick_winner(input logic req0, input logic req1,
                                               input logic fixed_prio, input logic rr_ptr);
        logic [1:0] w;
        w = GRANT_NONE;
        if (req0 && req1)
            w = (fixed_prio || rr_ptr) ? GRANT_M1 : GRANT_M0;
        else if (req1)
            w = GRANT_M1;
        else if (req0)
            w = GRANT_M0;
        return w;
    endfunction

endpackage

// File: rtl/axi_read_arbiter_if.sv
// AXI read address/data channel bundle; "self" is the view of the block
// serving a master, "master" is the view of the block driving a slave.
interface axi_read_if;
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arready;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic        rlast;

    modport self (
        input  arvalid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rlast
    );

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rlast
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// Two-master AXI read arbiter: one outstanding burst at a time, round-robin or
// fixed M1 priority, with a beat-count/rlast consistency monitor.
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    axi_read_if.self          m0_axi_read_if,
    axi_read_if.self          m1_axi_read_if,
    axi_read_if.master        s_axi_read_if,
    output logic [1:0]        grant,
    output logic              burst_err
);

    arb_state_e state;
    logic       rr_ptr;
    logic [7:0] len_q;
    logic [7:0] beat_cnt;

    logic       in_addr;
    logic       in_data;
    logic       sel_m1;
    logic       ar_fire;
    logic       r_fire;
    logic [7:0] granted_arlen;
    logic [1:0] winner;

    assign in_addr       = (state == ST_ADDR);
    assign in_data       = (state == ST_DATA);
    assign sel_m1        = grant[1];
    assign granted_arlen = sel_m1 ? m1_axi_read_if.arlen : m0_axi_read_if.arlen;
    assign winner        = pick_winner(m0_axi_read_if.arvalid, m1_axi_read_if.arvalid,
                                       FIXED_PRIO != 0, rr_ptr);
    assign ar_fire       = in_addr && s_axi_read_if.arvalid && s_axi_read_if.arready;
    assign r_fire        = in_data && s_axi_read_if.rvalid && s_axi_read_if.rready;

    // Slave side: address channel only in ADDR, rready only in DATA.
    always_comb begin
        s_axi_read_if.arvalid = 1'b0;
        s_axi_read_if.araddr  = '0;
        s_axi_read_if.arlen   = '0;
        s_axi_read_if.arsize  = '0;
        s_axi_read_if.arburst = '0;
        s_axi_read_if.rready  = 1'b0;
        if (in_addr) begin
            if (sel_m1) begin
                s_axi_read_if.arvalid = m1_axi_read_if.arvalid;
                s_axi_read_if.araddr  = m1_axi_read_if.araddr;
                s_axi_read_if.arlen   = m1_axi_read_if.arlen;
                s_axi_read_if.arsize  = m1_axi_read_if.arsize;
                s_axi_read_if.arburst = m1_axi_read_if.arburst;
            end else begin
                s_axi_read_if.arvalid = m0_axi_read_if.arvalid;
                s_axi_read_if.araddr  = m0_axi_read_if.araddr;
                s_axi_read_if.arlen   = m0_axi_read_if.arlen;
                s_axi_read_if.arsize  = m0_axi_read_if.arsize;
                s_axi_read_if.arburst = m0_axi_read_if.arburst;
            end
        end
        if (in_data)
            s_axi_read_if.rready = sel_m1 ? m1_axi_read_if.rready : m0_axi_read_if.rready;
    end

    // Master side: the non-granted master sees an idle, all-zero channel.
    always_comb begin
        m0_axi_read_if.arready = 1'b0;
        m0_axi_read_if.rvalid  = 1'b0;
        m0_axi_read_if.rdata   = '0;
        m0_axi_read_if.rlast   = 1'b0;
        m1_axi_read_if.arready = 1'b0;
        m1_axi_read_if.rvalid  = 1'b0;
        m1_axi_read_if.rdata   = '0;
        m1_axi_read_if.rlast   = 1'b0;
        if (in_addr) begin
            if (grant[0]) m0_axi_read_if.arready = s_axi_read_if.arready;
            if (grant[1]) m1_axi_read_if.arready = s_axi_read_if.arready;
        end
        if (in_data) begin
            if (grant[0]) begin
                m0_axi_read_if.rvalid = s_axi_read_if.rvalid;
                m0_axi_read_if.rdata  = s_axi_read_if.rdata;
                m0_axi_read_if.rlast  = s_axi_read_if.rlast;
            end
            if (grant[1]) begin
                m1_axi_read_if.rvalid = s_axi_read_if.rvalid;
                m1_axi_read_if.rdata  = s_axi_read_if.rdata;
                m1_axi_read_if.rlast  = s_axi_read_if.rlast;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            grant     <= GRANT_NONE;
            rr_ptr    <= 1'b0;
            len_q     <= '0;
            beat_cnt  <= '0;
            burst_err <= 1'b0;
        end else begin
            burst_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (winner != GRANT_NONE) begin
                        grant <= winner;
                        state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (ar_fire) begin
                        len_q    <= granted_arlen;
                        beat_cnt <= '0;
                        state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_fire) begin
                        beat_cnt  <= beat_cnt + 8'd1;
                        // beat_cnt is the index of the beat being accepted.
                        burst_err <= s_axi_read_if.rlast ? (beat_cnt != len_q)
                                                         : (beat_cnt == len_q);
                        if (s_axi_read_if.rlast) begin
                            state <= ST_IDLE;
                            grant <= GRANT_NONE;
                            if (FIXED_PRIO == 0)
                                rr_ptr <= grant[0];
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: one round-robin and one fixed-priority instance
// share the stimulus; a burst-level model predicts service order and timing.
module tb_axi_read_arbiter;
    import axi_read_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel;   // 0 observes the round-robin instance, 1 the fixed-priority one

    logic        m_arvalid [2];
    logic [31:0] m_araddr  [2];
    logic [7:0]  m_arlen   [2];
    logic [2:0]  m_arsize  [2];
    logic [1:0]  m_arburst [2];
    logic        m_rready  [2];
    logic        s_arready, s_rvalid, s_rlast;
    logic [31:0] s_rdata;

    for (genvar g = 0; g < 2; g++) begin : u
        axi_read_if m0i ();
        axi_read_if m1i ();
        axi_read_if si ();
        logic [1:0] grant;
        logic       burst_err;

        assign m0i.arvalid = m_arvalid[0];
        assign m0i.araddr  = m_araddr[0];
        assign m0i.arlen   = m_arlen[0];
        assign m0i.arsize  = m_arsize[0];
        assign m0i.arburst = m_arburst[0];
        assign m0i.rready  = m_rready[0];
        assign m1i.arvalid = m_arvalid[1];
        assign m1i.araddr  = m_araddr[1];
        assign m1i.arlen   = m_arlen[1];
        assign m1i.arsize  = m_arsize[1];
        assign m1i.arburst = m_arburst[1];
        assign m1i.rready  = m_rready[1];
        assign si.arready  = s_arready;
        assign si.rvalid   = s_rvalid;
        assign si.rdata    = s_rdata;
        assign si.rlast    = s_rlast;

        axi_read_arbiter #(.FIXED_PRIO(g)) dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .m0_axi_read_if (m0i),
            .m1_axi_read_if (m1i),
            .s_axi_read_if  (si),
            .grant          (grant),
            .burst_err      (burst_err)
        );
    end

    logic        o_m_arready [2];
    logic        o_m_rvalid  [2];
    logic        o_m_rlast   [2];
    logic [31:0] o_m_rdata   [2];
    logic        o_s_arvalid, o_s_rready, o_burst_err;
    logic [31:0] o_s_araddr;
    logic [7:0]  o_s_arlen;
    logic [2:0]  o_s_arsize;
    logic [1:0]  o_s_arburst, o_grant;

    assign o_m_arready[0] = sel ? u[1].m0i.arready : u[0].m0i.arready;
    assign o_m_rvalid[0]  = sel ? u[1].m0i.rvalid  : u[0].m0i.rvalid;
    assign o_m_rlast[0]   = sel ? u[1].m0i.rlast   : u[0].m0i.rlast;
    assign o_m_rdata[0]   = sel ? u[1].m0i.rdata   : u[0].m0i.rdata;
    assign o_m_arready[1] = sel ? u[1].m1i.arready : u[0].m1i.arready;
    assign o_m_rvalid[1]  = sel ? u[1].m1i.rvalid  : u[0].m1i.rvalid;
    assign o_m_rlast[1]   = sel ? u[1].m1i.rlast   : u[0].m1i.rlast;
    assign o_m_rdata[1]   = sel ? u[1].m1i.rdata   : u[0].m1i.rdata;
    assign o_s_arvalid    = sel ? u[1].si.arvalid  : u[0].si.arvalid;
    assign o_s_araddr     = sel ? u[1].si.araddr   : u[0].si.araddr;
    assign o_s_arlen      = sel ? u[1].si.arlen    : u[0].si.arlen;
    assign o_s_arsize     = sel ? u[1].si.arsize   : u[0].si.arsize;
    assign o_s_arburst    = sel ? u[1].si.arburst  : u[0].si.arburst;
    assign o_s_rready     = sel ? u[1].si.rready   : u[0].si.rready;
    assign o_grant        = sel ? u[1].grant       : u[0].grant;
    assign o_burst_err    = sel ? u[1].burst_err   : u[0].burst_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit pref = 1'b0;        // round-robin preference in the model: 1 = M1
    int last_fire = -100;   // cycle whose closing edge accepted the last rlast beat
    bit err_pend = 1'b0;    // burst_err expected in the current cycle

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input int m);
        return (m == 1) ? GRANT_M1 : GRANT_M0;
    endfunction

    task automatic clear_inputs();
        for (int m = 0; m < 2; m++) begin
            m_arvalid[m] = 1'b0;
            m_araddr[m]  = '0;
            m_arlen[m]   = '0;
            m_arsize[m]  = '0;
            m_arburst[m] = '0;
            m_rready[m]  = 1'b0;
        end
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rdata   = '0;
        s_rlast   = 1'b0;
    endtask

    task automatic raise(input int m, input int len, input logic [31:0] a);
        m_arvalid[m] = 1'b1;
        m_araddr[m]  = (a != 0) ? a : ($urandom() & 32'hFFFF_FFFC);
        m_arlen[m]   = 8'(len);
        m_arsize[m]  = ($urandom_range(0, 1) != 0) ? AXI_SIZE_4B : AXI_SIZE_2B;
        m_arburst[m] = ($urandom_range(0, 1) != 0) ? AXI_BURST_INCR : AXI_BURST_FIXED;
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst_n = 1'b0;
        m_arvalid[0] = 1'b1;
        m_arvalid[1] = 1'b1;
        @(negedge clk); cyc++;
        #1;
        chk("reset_grant", 32'(o_grant), 32'(GRANT_NONE));
        chk("reset_burst_err", 32'(o_burst_err), 32'd0);
        chk("reset_s_arvalid", 32'(o_s_arvalid), 32'd0);
        chk("reset_s_rready", 32'(o_s_rready), 32'd0);
        chk("reset_m0_arready", 32'(o_m_arready[0]), 32'd0);
        chk("reset_m1_arready", 32'(o_m_arready[1]), 32'd0);
        @(negedge clk); cyc++;
        clear_inputs();
        rst_n     = 1'b1;
        pref      = 1'b0;
        last_fire = -100;
        err_pend  = 1'b0;
    endtask

    // One arbitration round: the requested bursts are served to completion.
    // late0 >= 0 raises M0 once M1 has received that many beats; err_beat >= 0
    // makes the slave end the burst early; rst_beat >= 0 resets mid-burst.
    task automatic round(input bit r0, input bit r1, input int late0, input int err_beat,
                         input int rst_beat, input int fl0, input int fl1,
                         input logic [31:0] fa1);
        int order[$];
        int req_cyc[2];
        int rx[2];
        int lens[2];
        bit rx_hs[2];
        int cur, ready, first, sl_beat, sl_lastbeat;
        bit has_cur, phase_addr, sl_active, fire_ar, fire_r, late_done, granted;

        lens[0] = (fl0 >= 0) ? fl0 : int'($urandom_range(0, 7));
        lens[1] = (fl1 >= 0) ? fl1 : int'($urandom_range(0, 7));
        rx = '{0, 0};
        rx_hs = '{1'b0, 1'b0};
        req_cyc = '{0, 0};
        sl_active = 1'b0; fire_ar = 1'b0; fire_r = 1'b0; late_done = 1'b0;
        sl_beat = 0; sl_lastbeat = 0; cur = 0;
        if (r0 && r1) begin
            first = (sel || pref) ? 1 : 0;
            order.push_back(first);
            order.push_back(1 - first);
        end else if (r1) order.push_back(1);
        else if (r0) order.push_back(0);

        for (int it = 0; it < 1000; it++) begin
            @(negedge clk); cyc++;
            if (it == 0) begin
                if (r0) begin raise(0, lens[0], 32'd0); req_cyc[0] = cyc; end
                if (r1) begin raise(1, lens[1], fa1); req_cyc[1] = cyc; end
            end
            for (int m = 0; m < 2; m++) if (rx_hs[m]) rx[m]++;
            if (fire_ar) begin
                m_arvalid[cur] = 1'b0;
                sl_active   = 1'b1;
                sl_beat     = 0;
                sl_lastbeat = (err_beat >= 0) ? err_beat : lens[cur];
            end
            if (fire_r) begin
                if (sl_beat == sl_lastbeat) begin
                    sl_active = 1'b0;
                    chk("beats_delivered", 32'(rx[cur]), 32'(sl_lastbeat + 1));
                    last_fire = cyc - 1;
                    if (!sel) pref = (cur == 0);
                    void'(order.pop_front());
                end else begin
                    sl_beat++;
                end
            end
            if (rst_beat >= 0 && sl_active && sl_beat == rst_beat) begin
                m_rready[cur] = 1'b1;
                s_rvalid = 1'b1;
                s_rlast  = 1'b0;
                rst_n    = 1'b0;
                #1;
                chk("midburst_rst_grant", 32'(o_grant), 32'(GRANT_NONE));
                chk("midburst_rst_s_arvalid", 32'(o_s_arvalid), 32'd0);
                chk("midburst_rst_s_rready", 32'(o_s_rready), 32'd0);
                chk("midburst_rst_m_rvalid", 32'(o_m_rvalid[cur]), 32'd0);
                chk("midburst_rst_burst_err", 32'(o_burst_err), 32'd0);
                clear_inputs();
                @(negedge clk); cyc++;
                rst_n = 1'b1; pref = 1'b0; last_fire = -100; err_pend = 1'b0;
                return;
            end
            if (late0 >= 0 && !late_done && sl_active && cur == 1 && rx[1] == late0) begin
                raise(0, lens[0], 32'd0);
                req_cyc[0] = cyc;
                order.push_back(0);
                late_done = 1'b1;
            end

            has_cur    = (order.size() > 0);
            cur        = has_cur ? order[0] : 0;
            ready      = has_cur ? ((req_cyc[cur] > last_fire + 1) ? req_cyc[cur] : last_fire + 1) : 0;
            phase_addr = has_cur && !sl_active && (cyc >= ready + 1);

            s_arready = ($urandom_range(0, 3) != 0);
            if (sl_active) begin
                s_rvalid = ($urandom_range(0, 3) != 0);
                s_rdata  = $urandom();
                s_rlast  = (sl_beat == sl_lastbeat);
            end else begin
                s_rvalid = 1'b0; s_rdata = '0; s_rlast = 1'b0;
            end
            m_rready[0] = ($urandom_range(0, 3) != 0);
            m_rready[1] = ($urandom_range(0, 3) != 0);
            #1;

            chk("burst_err", 32'(o_burst_err), 32'(err_pend));
            chk("grant", 32'(o_grant), (phase_addr || sl_active) ? 32'(onehot(cur)) : 32'd0);
            chk("s_arvalid", 32'(o_s_arvalid), 32'(phase_addr));
            if (phase_addr) begin
                chk("s_araddr", o_s_araddr, m_araddr[cur]);
                chk("s_arlen", 32'(o_s_arlen), 32'(m_arlen[cur]));
                chk("s_arsize", 32'(o_s_arsize), 32'(m_arsize[cur]));
                chk("s_arburst", 32'(o_s_arburst), 32'(m_arburst[cur]));
                chk("granted_arready", 32'(o_m_arready[cur]), 32'(s_arready));
            end
            if (sl_active) begin
                chk("granted_rvalid", 32'(o_m_rvalid[cur]), 32'(s_rvalid));
                chk("granted_rdata", o_m_rdata[cur], s_rdata);
                chk("granted_rlast", 32'(o_m_rlast[cur]), 32'(s_rlast));
                chk("s_rready", 32'(o_s_rready), 32'(m_rready[cur]));
            end
            if (!has_cur) chk("idle_s_rready", 32'(o_s_rready), 32'd0);
            for (int m = 0; m < 2; m++) begin
                granted = (phase_addr || sl_active) && (m == cur);
                if (!granted) begin
                    chk("idle_master_arready", 32'(o_m_arready[m]), 32'd0);
                    chk("idle_master_rvalid", 32'(o_m_rvalid[m]), 32'd0);
                    chk("idle_master_rlast", 32'(o_m_rlast[m]), 32'd0);
                    chk("idle_master_rdata", o_m_rdata[m], 32'd0);
                end
            end

            fire_ar = has_cur && !sl_active && o_s_arvalid && s_arready;
            fire_r  = sl_active && s_rvalid && o_s_rready;
            err_pend = fire_r && (s_rlast != (sl_beat == lens[cur]));
            for (int m = 0; m < 2; m++) rx_hs[m] = o_m_rvalid[m] && m_rready[m];
            if (order.size() == 0) break;
        end
        chk("round_complete", 32'(order.size()), 32'd0);
    endtask

    initial begin
        logic [1:0] r;
        sel = 1'b0;
        reset_dut();
        round(1'b0, 1'b1, -1, -1, -1, -1, 7, 32'h0000_1000);   // lone M1, 8 beats
        round(1'b1, 1'b1, -1, -1, -1, -1, -1, 32'd0);          // contention, M0 first
        round(1'b1, 1'b0, -1, -1, -1, -1, -1, 32'd0);
        round(1'b1, 1'b1, -1, -1, -1, -1, -1, 32'd0);          // contention, M1 first
        round(1'b0, 1'b1, 3, -1, -1, -1, 7, 32'd0);            // M0 arrives mid-burst
        round(1'b1, 1'b0, -1, 6, -1, 7, -1, 32'd0);            // early rlast
        round(1'b1, 1'b0, -1, -1, 4, 7, -1, 32'd0);            // reset at beat 4
        round(1'b1, 1'b0, -1, -1, -1, -1, -1, 32'd0);
        for (int i = 0; i < 16; i++) begin
            r = 2'($urandom_range(1, 3));
            round(r[0], r[1], -1, -1, -1, -1, -1, 32'd0);
        end

        sel = 1'b1;
        reset_dut();
        round(1'b1, 1'b1, -1, -1, -1, -1, -1, 32'd0);
        round(1'b1, 1'b1, -1, -1, -1, -1, -1, 32'd0);
        for (int i = 0; i < 8; i++) begin
            r = 2'($urandom_range(1, 3));
            round(r[0], r[1], -1, -1, -1, -1, -1, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
